// File: rtl/fetch_stage.sv
// fetch_stage: RV32I instruction-fetch stage feeding decode.
// Owns the PC, keeps at most one word fetch in flight, and presents each
// returned instruction on a registered IF/ID output. Decode back-pressure
// is absorbed by a one-entry hold buffer. Execute redirects drop stale
// fetches.
// Optional feature macro: FETCH_MISALIGN_CHECK_EN (misaligned-redirect FAULT).
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instri,
    output logic [31:0] instr_pc,
    output logic        misaligned
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inflight_pc_q, inflight_pc_d;
    logic        discard_q, discard_d;
    logic [31:0] hold_data_q, hold_data_d;
    logic [31:0] hold_pc_q, hold_pc_d;
    logic        instr_valid_q, instr_valid_d;
    logic [31:0] instri_q, instri_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic        misaligned_q, misaligned_d;

    logic [31:0] redirect_tgt;
    logic        redirect_bad;
    logic        accept;
    logic        owed;

`ifdef FETCH_MISALIGN_CHECK_EN
    // A misaligned target is kept as-is so the fault reports the exact address.
    assign redirect_tgt = redirect_pc;
    assign redirect_bad = |redirect_pc[1:0];
`else
    // Without the check the low bits are simply ignored.
    logic unused_redirect_lsb;
    assign unused_redirect_lsb = ^redirect_pc[1:0];
    assign redirect_tgt = {redirect_pc[31:2], 2'b00};
    assign redirect_bad = 1'b0;
`endif

    assign accept         = (state_q == S_REQ) && imem_req_ready;
    assign imem_req_valid = (state_q == S_REQ) && !rst;
    assign imem_req_addr  = pc_q;
    assign instr_valid    = instr_valid_q;
    assign instri         = instri_q;
    assign instr_pc       = instr_pc_q;
    assign misaligned     = misaligned_q;

    // Next-state and output-register logic; redirect overrides every state.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        inflight_pc_d = inflight_pc_q;
        discard_d     = discard_q;
        hold_data_d   = hold_data_q;
        hold_pc_d     = hold_pc_q;
        instr_valid_d = instr_valid_q && stall;   // consumed output empties
        instri_d      = instri_q;
        instr_pc_d    = instr_pc_q;
        misaligned_d  = misaligned_q;
        // A fetch whose response has not yet returned by the end of this cycle
        owed = accept
            || ((state_q == S_WAIT) && !imem_rsp_valid)
            || ((state_q == S_FAULT) && discard_q && !imem_rsp_valid);

        if (redirect) begin
            pc_d          = redirect_tgt;
            instr_valid_d = 1'b0;
            misaligned_d  = 1'b0;
            discard_d     = owed;
            if (redirect_bad) begin
                state_d       = S_FAULT;
                instr_valid_d = 1'b1;
                instri_d      = NOP;
                instr_pc_d    = redirect_tgt;
                misaligned_d  = 1'b1;
            end else begin
                state_d = owed ? S_WAIT : S_REQ;
            end
        end else begin
            unique case (state_q)
                S_REQ: begin
                    if (imem_req_ready) begin
                        inflight_pc_d = pc_q;
                        pc_d          = pc_q + 32'd4;
                        state_d       = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        state_d = S_REQ;
                        if (discard_q) begin
                            discard_d = 1'b0;
                        end else if (!instr_valid_q || !stall) begin
                            instr_valid_d = 1'b1;
                            instri_d      = imem_rsp_data;
                            instr_pc_d    = inflight_pc_q;
                        end else begin
                            hold_data_d = imem_rsp_data;
                            hold_pc_d   = inflight_pc_q;
                            state_d     = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        instr_valid_d = 1'b1;
                        instri_d      = hold_data_q;
                        instr_pc_d    = hold_pc_q;
                        state_d       = S_REQ;
                    end
                end
                S_FAULT: begin
                    // Fault word is held regardless of stall; a stale
                    // response may still be owed and is silently absorbed.
                    instr_valid_d = 1'b1;
                    if (discard_q && imem_rsp_valid) begin
                        discard_d = 1'b0;
                    end
                end
                default: state_d = S_REQ;
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_REQ;
            pc_q          <= RESET_PC;
            inflight_pc_q <= 32'd0;
            discard_q     <= 1'b0;
            hold_data_q   <= 32'd0;
            hold_pc_q     <= 32'd0;
            instr_valid_q <= 1'b0;
            instri_q      <= 32'd0;
            instr_pc_q    <= 32'd0;
            misaligned_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            inflight_pc_q <= inflight_pc_d;
            discard_q     <= discard_d;
            hold_data_q   <= hold_data_d;
            hold_pc_q     <= hold_pc_d;
            instr_valid_q <= instr_valid_d;
            instri_q      <= instri_d;
            instr_pc_q    <= instr_pc_d;
            misaligned_q  <= misaligned_d;
        end
    end

endmodule
